// File: rtl/decode_stage.sv
// Registered MIPS32-subset instruction decode stage feeding the ID/EX pipeline register.
// Define LOAD_STORE_EN to add lw/sw decode and the one-cycle load-use interlock.
module decode_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_instr,
    input  logic               stall_in,
    input  logic               flush_in,
    output logic [REG_AW-1:0]  raddr1,
    output logic [REG_AW-1:0]  raddr2,
    output logic               id_stall_req,
    output logic               ex_valid,
    output logic [1:0]         ex_instr_type,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [DATA_W-1:0]  ex_ext_imm,
    output logic [REG_AW-1:0]  ex_raddr1,
    output logic [REG_AW-1:0]  ex_raddr2,
    output logic [REG_AW-1:0]  ex_waddr,
    output logic               ex_reg_wr,
    output logic               ex_mem_wr,
    output logic               ex_mem_rd,
    output logic               ex_illegal
);

    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_NOR = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(5);

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_I = 2'b01;

    typedef struct packed {
        logic               valid;
        logic [1:0]         itype;
        logic [ALUOP_W-1:0] aluop;
        logic [DATA_W-1:0]  ext_imm;
        logic [REG_AW-1:0]  raddr1;
        logic [REG_AW-1:0]  raddr2;
        logic [REG_AW-1:0]  waddr;
        logic               reg_wr;
        logic               mem_wr;
        logic               mem_rd;
        logic               illegal;
    } idex_t;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              unused_shamt;

    idex_t dec;
    idex_t launch;
    idex_t ex_q;

    assign op           = id_instr[31:26];
    assign funct        = id_instr[5:0];
    assign imm          = id_instr[15:0];
    assign rs           = REG_AW'(id_instr[25:21]);
    assign rt           = REG_AW'(id_instr[20:16]);
    assign rd           = REG_AW'(id_instr[15:11]);
    assign unused_shamt = ^id_instr[10:6];

    // Field decode; unrecognised encodings collapse to an illegal marker with everything else zero.
    always_comb begin
        dec       = '0;
        dec.valid = id_valid;
        unique case (op)
            6'h00: begin
                dec.itype  = TYPE_R;
                dec.raddr1 = rs;
                dec.raddr2 = rt;
                dec.waddr  = rd;
                dec.reg_wr = 1'b1;
                case (funct)
                    6'h25:   dec.aluop = ALU_OR;
                    6'h24:   dec.aluop = ALU_AND;
                    6'h26:   dec.aluop = ALU_XOR;
                    6'h27:   dec.aluop = ALU_NOR;
                    6'h21:   dec.aluop = ALU_ADD;
                    default: dec.illegal = 1'b1;
                endcase
            end
            6'h0D, 6'h0C, 6'h0E, 6'h09: begin
                dec.itype  = TYPE_I;
                dec.raddr1 = rs;
                dec.waddr  = rt;
                dec.reg_wr = 1'b1;
                dec.ext_imm = DATA_W'(imm);
                case (op)
                    6'h0C:   dec.aluop = ALU_AND;
                    6'h0E:   dec.aluop = ALU_XOR;
                    6'h09: begin
                        dec.aluop   = ALU_ADD;
                        dec.ext_imm = DATA_W'($signed(imm));
                    end
                    default: dec.aluop = ALU_OR;
                endcase
            end
            6'h0F: begin
                dec.itype   = TYPE_I;
                dec.aluop   = ALU_LUI;
                dec.ext_imm = DATA_W'({imm, 16'h0000});
                dec.waddr   = rt;
                dec.reg_wr  = 1'b1;
            end
`ifdef LOAD_STORE_EN
            6'h23: begin
                dec.itype   = TYPE_I;
                dec.aluop   = ALU_ADD;
                dec.ext_imm = DATA_W'($signed(imm));
                dec.raddr1  = rs;
                dec.waddr   = rt;
                dec.reg_wr  = 1'b1;
                dec.mem_rd  = 1'b1;
            end
            6'h2B: begin
                dec.itype   = TYPE_I;
                dec.aluop   = ALU_ADD;
                dec.ext_imm = DATA_W'($signed(imm));
                dec.raddr1  = rs;
                dec.raddr2  = rt;
                dec.mem_wr  = 1'b1;
            end
`endif
            default: dec.illegal = 1'b1;
        endcase
        if (dec.waddr == '0) begin
            dec.reg_wr = 1'b0;
        end
        if (dec.illegal) begin
            dec         = '0;
            dec.valid   = id_valid;
            dec.illegal = 1'b1;
        end
    end

    assign raddr1 = dec.raddr1;
    assign raddr2 = dec.raddr2;
    assign launch = id_valid ? dec : '0;

`ifdef LOAD_STORE_EN
    // Load-use: the instruction in EX is a load whose destination this instruction reads.
    assign id_stall_req = ~rst & id_valid & ex_q.valid & ex_q.mem_rd & (ex_q.waddr != '0)
                        & ((ex_q.waddr == dec.raddr1) | (ex_q.waddr == dec.raddr2));
`else
    assign id_stall_req = 1'b0;
`endif

    // ID/EX register: reset > flush bubble > downstream hold > interlock bubble > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush_in) begin
            ex_q <= '0;
        end else if (stall_in) begin
            ex_q <= ex_q;
        end else if (id_stall_req) begin
            ex_q <= '0;
        end else begin
            ex_q <= launch;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_instr_type = ex_q.itype;
    assign ex_aluop      = ex_q.aluop;
    assign ex_ext_imm    = ex_q.ext_imm;
    assign ex_raddr1     = ex_q.raddr1;
    assign ex_raddr2     = ex_q.raddr2;
    assign ex_waddr      = ex_q.waddr;
    assign ex_reg_wr     = ex_q.reg_wr;
    assign ex_mem_wr     = ex_q.mem_wr;
    assign ex_mem_rd     = ex_q.mem_rd;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues expected ID/EX contents, monitor checks after each edge.
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [1:0]  itype;
        logic [2:0]  aluop;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wa;
        logic        rw;
        logic        mw;
        logic        mr;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        stall_in;
    logic        flush_in;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        id_stall_req;
    logic        ex_valid;
    logic [1:0]  ex_instr_type;
    logic [2:0]  ex_aluop;
    logic [31:0] ex_ext_imm;
    logic [4:0]  ex_raddr1;
    logic [4:0]  ex_raddr2;
    logic [4:0]  ex_waddr;
    logic        ex_reg_wr;
    logic        ex_mem_wr;
    logic        ex_mem_rd;
    logic        ex_illegal;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_instr     (id_instr),
        .stall_in     (stall_in),
        .flush_in     (flush_in),
        .raddr1       (raddr1),
        .raddr2       (raddr2),
        .id_stall_req (id_stall_req),
        .ex_valid     (ex_valid),
        .ex_instr_type(ex_instr_type),
        .ex_aluop     (ex_aluop),
        .ex_ext_imm   (ex_ext_imm),
        .ex_raddr1    (ex_raddr1),
        .ex_raddr2    (ex_raddr2),
        .ex_waddr     (ex_waddr),
        .ex_reg_wr    (ex_reg_wr),
        .ex_mem_wr    (ex_mem_wr),
        .ex_mem_rd    (ex_mem_rd),
        .ex_illegal   (ex_illegal)
    );

    function automatic exp_t mk(input logic v, input logic [1:0] t, input logic [2:0] op,
                                input logic [31:0] imm, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] wa, input logic rw, input logic mw,
                                input logic mr, input logic ill);
        exp_t e;
        e = '{valid: v, itype: t, aluop: op, imm: imm, r1: r1, r2: r2, wa: wa,
              rw: rw, mw: mw, mr: mr, ill: ill};
        return e;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("v=%0b t=%0d op=%0d imm=%h r1=%0d r2=%0d wa=%0d rw=%0b mw=%0b mr=%0b ill=%0b",
                         x.valid, x.itype, x.aluop, x.imm, x.r1, x.r2, x.wa, x.rw, x.mw, x.mr, x.ill);
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check the combinational outputs, queue the expected ID/EX state.
    task automatic step(input logic r, input logic v, input logic s, input logic f,
                        input logic [31:0] ins, input exp_t e, input logic e_sr,
                        input logic [4:0] e_r1, input logic [4:0] e_r2);
        @(negedge clk);
        rst      = r;
        id_valid = v;
        stall_in = s;
        flush_in = f;
        id_instr = ins;
        #1;
        check_val($sformatf("raddr1[%h]", ins), 32'(raddr1), 32'(e_r1));
        check_val($sformatf("raddr2[%h]", ins), 32'(raddr2), 32'(e_r2));
        check_val($sformatf("id_stall_req[%h]", ins), 32'(id_stall_req), 32'(e_sr));
        sb.push_back(e);
    endtask

    // Monitor: compare the registered ID/EX bundle after every edge that has an expectation queued.
    initial begin
        exp_t e;
        exp_t a;
        int   n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = '{valid: ex_valid, itype: ex_instr_type, aluop: ex_aluop, imm: ex_ext_imm,
                      r1: ex_raddr1, r2: ex_raddr2, wa: ex_waddr, rw: ex_reg_wr,
                      mw: ex_mem_wr, mr: ex_mem_rd, ill: ex_illegal};
                checks++;
                if (a !== e) begin
                    failures++;
                    $display("FAIL ex_bundle#%0d: got %s expected %s", n, fmt(a), fmt(e));
                end
                n++;
            end
        end
    end

    initial begin
        exp_t z, e_ori, e_ill;
        z     = '0;
        e_ori = mk(1, 2'd1, 3'd0, 32'h0000_00FF, 5'd0, 5'd0, 5'd1, 1, 0, 0, 0);
        e_ill = mk(1, 2'd0, 3'd0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);

        rst      = 1'b1;
        id_valid = 1'b1;
        id_instr = 32'h3401_00FF;
        stall_in = 1'b0;
        flush_in = 1'b0;

        // reset holds everything at zero
        step(1, 1, 0, 0, 32'h3401_00FF, z, 0, 5'd0, 5'd0);
        step(1, 1, 0, 0, 32'h3401_00FF, z, 0, 5'd0, 5'd0);

        // I-type immediates
        step(0, 1, 0, 0, 32'h3401_00FF, e_ori, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h2404_FFFF, mk(1, 2'd1, 3'd4, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0), 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h3C05_1234, mk(1, 2'd1, 3'd5, 32'h1234_0000, 5'd0, 5'd0, 5'd5, 1, 0, 0, 0), 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h30A7_F0F0, mk(1, 2'd1, 3'd1, 32'h0000_F0F0, 5'd5, 5'd0, 5'd7, 1, 0, 0, 0), 0, 5'd5, 5'd0);
        step(0, 1, 0, 0, 32'h38E8_8001, mk(1, 2'd1, 3'd2, 32'h0000_8001, 5'd7, 5'd0, 5'd8, 1, 0, 0, 0), 0, 5'd7, 5'd0);

        // R-type logic ops
        step(0, 1, 0, 0, 32'h00E8_3025, mk(1, 2'd0, 3'd0, 32'h0, 5'd7, 5'd8, 5'd6, 1, 0, 0, 0), 0, 5'd7, 5'd8);
        step(0, 1, 0, 0, 32'h014B_4827, mk(1, 2'd0, 3'd3, 32'h0, 5'd10, 5'd11, 5'd9, 1, 0, 0, 0), 0, 5'd10, 5'd11);
        step(0, 1, 0, 0, 32'h0022_6024, mk(1, 2'd0, 3'd1, 32'h0, 5'd1, 5'd2, 5'd12, 1, 0, 0, 0), 0, 5'd1, 5'd2);
        step(0, 1, 0, 0, 32'h0064_6826, mk(1, 2'd0, 3'd2, 32'h0, 5'd3, 5'd4, 5'd13, 1, 0, 0, 0), 0, 5'd3, 5'd4);

        // loads, stores and the load-use interlock
`ifdef LOAD_STORE_EN
        step(0, 1, 0, 0, 32'h8C22_0004, mk(1, 2'd1, 3'd4, 32'h0000_0004, 5'd1, 5'd0, 5'd2, 1, 0, 1, 0), 0, 5'd1, 5'd0);
        step(0, 1, 0, 0, 32'h0041_1821, z, 1, 5'd2, 5'd1);
        step(0, 1, 0, 0, 32'h0041_1821, mk(1, 2'd0, 3'd4, 32'h0, 5'd2, 5'd1, 5'd3, 1, 0, 0, 0), 0, 5'd2, 5'd1);
        step(0, 1, 0, 0, 32'h8C22_0004, mk(1, 2'd1, 3'd4, 32'h0000_0004, 5'd1, 5'd0, 5'd2, 1, 0, 1, 0), 0, 5'd1, 5'd0);
        step(0, 1, 0, 0, 32'h3401_00FF, e_ori, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'hAC45_0008, mk(1, 2'd1, 3'd4, 32'h0000_0008, 5'd2, 5'd5, 5'd0, 0, 1, 0, 0), 0, 5'd2, 5'd5);
`else
        step(0, 1, 0, 0, 32'h8C22_0004, e_ill, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h0041_1821, mk(1, 2'd0, 3'd4, 32'h0, 5'd2, 5'd1, 5'd3, 1, 0, 0, 0), 0, 5'd2, 5'd1);
        step(0, 1, 0, 0, 32'h8C22_0004, e_ill, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h3401_00FF, e_ori, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'hAC45_0008, e_ill, 0, 5'd0, 5'd0);
`endif

        // downstream stall freezes EX, flush beats stall, id_valid=0 launches a bubble
        step(0, 1, 0, 0, 32'h3401_00FF, e_ori, 0, 5'd0, 5'd0);
        step(0, 1, 1, 0, 32'h3C05_1234, e_ori, 0, 5'd0, 5'd0);
        step(0, 1, 1, 0, 32'h30A7_F0F0, e_ori, 0, 5'd5, 5'd0);
        step(0, 1, 1, 0, 32'h00E8_3025, e_ori, 0, 5'd7, 5'd8);
        step(0, 1, 1, 1, 32'h00E8_3025, z, 0, 5'd7, 5'd8);
        step(0, 0, 0, 0, 32'h00E8_3025, z, 0, 5'd7, 5'd8);

        // illegal encodings and writes to $0
        step(0, 1, 0, 0, 32'hFC00_0000, e_ill, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h0022_1800, e_ill, 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h3400_0005, mk(1, 2'd1, 3'd0, 32'h0000_0005, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0), 0, 5'd0, 5'd0);
        step(0, 1, 0, 0, 32'h00E8_0025, mk(1, 2'd0, 3'd0, 32'h0, 5'd7, 5'd8, 5'd0, 0, 0, 0, 0), 0, 5'd7, 5'd8);

        // reset mid-stream clears a live stage
        step(1, 1, 0, 0, 32'h3401_00FF, z, 0, 5'd0, 5'd0);

        @(negedge clk);
        @(negedge clk);
        check_val("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
